// File: rtl/alu_operand_fetch_pkg.sv
// Shared definitions for the ALU operand-fetch stage: widths, opcodes, instruction fields.
// No logic of its own; pure constants plus a small opcode classifier.
// Imported by the interface, the register file and the stage top.
package alu_operand_fetch_pkg;

  localparam int REG_W = 16;
  localparam int RF_AW = 3;

  typedef logic [REG_W-1:0] word_t;
  typedef logic [RF_AW-1:0] raddr_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_ADDSH = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_ADD2B = 4'b0011;
  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_SHL   = 4'b0110;
  localparam logic [3:0] OP_BA2B  = 4'b0111;

  // Instruction word field positions
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 9;
  localparam int RS_MSB = 8;
  localparam int RS_LSB = 6;
  localparam int RT_MSB = 5;
  localparam int RT_LSB = 3;
  localparam int BA_BIT = 2;

  // Real ALU operations commit Out/Carry_out; the upper half of the opcode space is NOP.
  function automatic logic op_commits(input logic [3:0] op);
    logic res;
    case (op)
      OP_ADD, OP_ADDSH, OP_SUB, OP_ADD2B,
      OP_MUL, OP_AND, OP_SHL, OP_BA2B: res = 1'b1;
      default:                          res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_operand_fetch_if.sv
// Bundle of instruction handshake, ALU drive/return, writeback and debug-read signals.
// Pure wiring, no latency.
// In_ready is produced by the stage (slave) and never depends on In_valid.
interface alu_operand_fetch_if;
  import alu_operand_fetch_pkg::*;

  logic          In_valid;
  logic          In_ready;
  logic [15:0]   Instr;
  word_t         A;
  word_t         B;
  logic [3:0]    OP;
  logic          BA;
  word_t         Result;
  logic          Carry_in;
  logic          Wb_valid;
  raddr_t        Wb_addr;
  word_t         Wb_data;
  logic          Carry_flag;
  raddr_t        Rd_addr;
  word_t         Rd_data;

  // Upstream / ALU / debug side
  modport master (
    output In_valid, Instr, Result, Carry_in, Rd_addr,
    input  In_ready, A, B, OP, BA, Wb_valid, Wb_addr, Wb_data, Carry_flag, Rd_data
  );

  // Operand-fetch stage side
  modport slave (
    input  In_valid, Instr, Result, Carry_in, Rd_addr,
    output In_ready, A, B, OP, BA, Wb_valid, Wb_addr, Wb_data, Carry_flag, Rd_data
  );

endinterface

// File: rtl/alu_operand_fetch_regfile.sv
// 8x16 register file: two operand read ports, one debug read port, one write port; r0 reads zero.
// Reads combinational, write lands at the rising edge.
// No backpressure; writes to r0 are dropped.
module alu_regfile
  import alu_operand_fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   we_i,
  input  raddr_t waddr_i,
  input  word_t  wdata_i,
  input  raddr_t raddr_a_i,
  output word_t  rdata_a_o,
  input  raddr_t raddr_b_i,
  output word_t  rdata_b_o,
  input  raddr_t raddr_d_i,
  output word_t  rdata_d_o
);

  localparam int DEPTH = 1 << RF_AW;

  word_t mem_q [DEPTH];

  // Storage: cleared on reset, single write per edge, r0 never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];
  assign rdata_d_o = (raddr_d_i == '0) ? '0 : mem_q[raddr_d_i];

endmodule

// File: rtl/alu_operand_fetch.sv
// Decode, operand fetch with writeback bypass, registered ALU issue and result writeback.
// One cycle issue-to-commit; OP_MUL holds the execute slot for MUL_CYCLES cycles.
// In_ready drops while a multiply still has cycles left; otherwise accepts every cycle.
module alu_operand_fetch
  import alu_operand_fetch_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_operand_fetch_if.slave   bus
);

  // Counter preload: a multiply counts down to zero, everything else is done at once
  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES - 1);

  // Execute register set
  logic       e_valid_q, e_valid_d;
  logic [3:0] e_op_q,    e_op_d;
  logic       e_ba_q,    e_ba_d;
  raddr_t     e_rd_q,    e_rd_d;
  word_t      e_a_q,     e_a_d;
  word_t      e_b_q,     e_b_d;
  logic [3:0] cnt_q,     cnt_d;
  logic       carry_q,   carry_d;

  // Decoded incoming instruction
  logic [3:0] in_op;
  raddr_t     in_rd;
  raddr_t     in_rs;
  raddr_t     in_rt;
  logic       in_ba;
  logic       unused_instr_bits;

  assign in_op = bus.Instr[OP_MSB:OP_LSB];
  assign in_rd = bus.Instr[RD_MSB:RD_LSB];
  assign in_rs = bus.Instr[RS_MSB:RS_LSB];
  assign in_rt = bus.Instr[RT_MSB:RT_LSB];
  assign in_ba = bus.Instr[BA_BIT];
  assign unused_instr_bits = ^bus.Instr[1:0];

  // Handshake and commit qualifiers
  logic done;
  logic in_ready;
  logic accept;
  logic commit;
  logic wb_valid;

  assign done     = e_valid_q && (cnt_q == 4'd0);
  assign in_ready = !e_valid_q || done;
  assign accept   = bus.In_valid && in_ready;
  assign commit   = done && op_commits(e_op_q);
  assign wb_valid = commit && (e_rd_q != '0);

  // Register file reads and bypass of the value being written this edge.
  // wb_valid already excludes r0, so a bypass can never come from index 0.
  word_t rf_a;
  word_t rf_b;
  word_t opnd_a;
  word_t opnd_b;

  alu_regfile u_rf (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_valid),
    .waddr_i   (e_rd_q),
    .wdata_i   (bus.Result),
    .raddr_a_i (in_rs),
    .rdata_a_o (rf_a),
    .raddr_b_i (in_rt),
    .rdata_b_o (rf_b),
    .raddr_d_i (bus.Rd_addr),
    .rdata_d_o (bus.Rd_data)
  );

  assign opnd_a = (wb_valid && (e_rd_q == in_rs)) ? bus.Result : rf_a;
  assign opnd_b = (wb_valid && (e_rd_q == in_rt)) ? bus.Result : rf_b;

  // Next-state: load on accept, otherwise retire or count down; operands hold when idle
  always_comb begin
    e_valid_d = e_valid_q;
    e_op_d    = e_op_q;
    e_ba_d    = e_ba_q;
    e_rd_d    = e_rd_q;
    e_a_d     = e_a_q;
    e_b_d     = e_b_q;
    cnt_d     = cnt_q;
    carry_d   = commit ? bus.Carry_in : carry_q;
    if (accept) begin
      e_valid_d = 1'b1;
      e_op_d    = in_op;
      e_ba_d    = in_ba;
      e_rd_d    = in_rd;
      e_a_d     = opnd_a;
      e_b_d     = opnd_b;
      cnt_d     = (in_op == OP_MUL) ? MUL_CNT : 4'd0;
    end else if (done) begin
      e_valid_d = 1'b0;
    end else if (e_valid_q) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Execute state and carry flag; reset aborts any in-flight instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid_q <= 1'b0;
      e_op_q    <= '0;
      e_ba_q    <= 1'b0;
      e_rd_q    <= '0;
      e_a_q     <= '0;
      e_b_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      e_valid_q <= e_valid_d;
      e_op_q    <= e_op_d;
      e_ba_q    <= e_ba_d;
      e_rd_q    <= e_rd_d;
      e_a_q     <= e_a_d;
      e_b_q     <= e_b_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
    end
  end

  assign bus.In_ready   = in_ready;
  assign bus.A          = e_a_q;
  assign bus.B          = e_b_q;
  assign bus.OP         = e_op_q;
  assign bus.BA         = e_ba_q;
  assign bus.Wb_valid   = wb_valid;
  assign bus.Wb_addr    = e_rd_q;
  assign bus.Wb_data    = bus.Result;
  assign bus.Carry_flag = carry_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Bench for alu_operand_fetch with a behavioural ALU attached and a sequential reference model.
module tb_alu_operand_fetch;
  import alu_operand_fetch_pkg::*;

  localparam int MULC = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_operand_fetch_if bus ();

  alu_operand_fetch #(.MUL_CYCLES(MULC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ALU: returns {carry, out}
  function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op, input logic ba);
    logic [16:0] s;
    logic [31:0] p;
    p = {16'd0, a} * {16'd0, b};
    case (op)
      OP_ADD:   s = {1'b0, a} + {1'b0, b};
      OP_ADDSH: s = {1'b0, a} + {1'b0, b[14:0], 1'b0};
      OP_SUB:   s = {1'b0, a} + {1'b0, ~b} + 17'd1;
      OP_ADD2B: s = {1'b0, a} + {1'b0, b} + {16'd0, ba};
      OP_MUL:   s = {|p[31:16], p[15:0]};
      OP_AND:   s = {1'b0, a & b};
      OP_SHL:   s = {a[15], a[14:0], 1'b0};
      OP_BA2B:  s = {16'd0, ba};
      default:  s = '0;
    endcase
    return s;
  endfunction

  always_comb {bus.Carry_in, bus.Result} = alu_f(bus.A, bus.B, bus.OP, bus.BA);

  // Reference model: architectural registers plus the instruction currently executing
  logic [15:0] rf_m [8];
  logic        carry_m;
  logic        m_v;
  logic [3:0]  m_op;
  logic        m_ba;
  logic [2:0]  m_rd;
  logic [15:0] m_a;
  logic [15:0] m_b;
  int          m_rem;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    carry_m = 1'b0;
    m_v = 1'b0; m_op = '0; m_ba = 1'b0; m_rd = '0; m_a = '0; m_b = '0; m_rem = 0;
  endtask

  // Called at a falling edge: reset is raised mid-cycle and takes effect at once
  task automatic do_reset();
    rst = 1'b1;
    bus.In_valid = 1'b0;
    #1;
    model_clear();
    check("rst_A", bus.A, 16'h0);
    check("rst_B", bus.B, 16'h0);
    check("rst_OP", 16'(bus.OP), 16'h0);
    check("rst_BA", 16'(bus.BA), 16'h0);
    check("rst_wb_valid", 16'(bus.Wb_valid), 16'h0);
    check("rst_in_ready", 16'(bus.In_ready), 16'h1);
    check("rst_carry", 16'(bus.Carry_flag), 16'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Idle-only sweep of the debug port
  task automatic rd_sweep();
    for (int i = 0; i < 8; i++) begin
      bus.Rd_addr = 3'(i);
      #1;
      check("rd_sweep", bus.Rd_data, rf_m[i]);
      @(negedge clk);
    end
  endtask

  // One cycle: check outputs against the model, drive inputs, advance the model by one edge
  task automatic step(input logic v, input logic [15:0] ins, input logic [2:0] ra, output logic acc);
    logic [16:0] res;
    logic        exp_rdy;
    logic        exp_wb;
    logic [3:0]  op;
    bus.Rd_addr = ra;
    #1;
    res     = alu_f(m_a, m_b, m_op, m_ba);
    exp_rdy = !m_v || (m_rem == 1);
    exp_wb  = m_v && (m_rem == 1) && !m_op[3] && (m_rd != 3'd0);
    check("in_ready", 16'(bus.In_ready), 16'(exp_rdy));
    check("A", bus.A, m_a);
    check("B", bus.B, m_b);
    check("OP", 16'(bus.OP), 16'(m_op));
    check("BA", 16'(bus.BA), 16'(m_ba));
    check("wb_valid", 16'(bus.Wb_valid), 16'(exp_wb));
    if (exp_wb) begin
      check("wb_addr", 16'(bus.Wb_addr), 16'(m_rd));
      check("wb_data", bus.Wb_data, res[15:0]);
    end
    check("carry_flag", 16'(bus.Carry_flag), 16'(carry_m));
    check("rd_data", bus.Rd_data, rf_m[ra]);

    bus.In_valid = v;
    bus.Instr    = ins;
    acc = v && exp_rdy;

    if (m_v && (m_rem == 1) && !m_op[3]) begin
      carry_m = res[16];
      if (m_rd != 3'd0) rf_m[m_rd] = res[15:0];
    end
    if (acc) begin
      op    = ins[15:12];
      m_v   = 1'b1;
      m_op  = op;
      m_rd  = ins[11:9];
      m_a   = rf_m[ins[8:6]];
      m_b   = rf_m[ins[5:3]];
      m_ba  = ins[2];
      m_rem = (op == OP_MUL) ? MULC : 1;
    end else if (m_v) begin
      if (m_rem == 1) m_v = 1'b0;
      else m_rem--;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [15:0] ins);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) step(1'b1, ins, 3'($urandom_range(0, 7)), acc);
    check("issue_accepted", 16'(acc), 16'h1);
  endtask

  task automatic idle(input int n, input logic [2:0] ra);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, 16'h0, ra, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    bus.In_valid = 1'b0;
    bus.Instr    = '0;
    bus.Rd_addr  = '0;
    model_clear();

    // Reset raised mid-cycle, then every register reads zero
    @(negedge clk);
    do_reset();
    rd_sweep();

    // BA2B into r1, read it back
    issue(16'h7204);
    idle(2, 3'd1);

    // Back-to-back dependent pair through the bypass, then r3 = r1 + r2
    issue(16'h7204);
    issue(16'h0448);
    issue(16'h0650);
    idle(2, 3'd3);

    // Multicycle multiply r4 = r2 * r3
    issue(16'h4898);
    idle(4, 3'd4);

    // Write to r0 is discarded; NOP leaves flags and registers alone
    issue(16'h0090);
    issue(16'h8248);
    idle(2, 3'd0);

    // Multiply aborted by reset on its second cycle
    issue(16'h4898);
    idle(1, 3'd4);
    do_reset();
    rd_sweep();

    // Randomized traffic with one reset in the middle
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom_range(0, 7)), acc);
      end
    end
    idle(MULC + 2, 3'd0);
    bus.In_valid = 1'b0;
    rd_sweep();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
